// File: rtl/bp_pkg.sv
// Shared branch-predictor types, index hash and 2-bit saturating counter helpers.
package bp_pkg;

  localparam int unsigned HIST_W    = 10;
  localparam int unsigned PC_LSB    = 2;
  localparam int unsigned PHT_DEPTH = 1 << HIST_W;

  typedef logic [1:0]        ctr2_t;
  typedef logic [HIST_W-1:0] pht_idx_t;

  localparam ctr2_t CTR_SNT = 2'd0;
  localparam ctr2_t CTR_WNT = 2'd1;
  localparam ctr2_t CTR_WT  = 2'd2;
  localparam ctr2_t CTR_ST  = 2'd3;

  function automatic ctr2_t sat_update(ctr2_t ctr, logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr2_t'(ctr + 2'd1);
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr2_t'(ctr - 2'd1);
  endfunction

  function automatic pht_idx_t pht_hash(pht_idx_t hist, logic [63:0] pc);
    return hist ^ pc[PC_LSB+HIST_W-1:PC_LSB];
  endfunction

endpackage

// File: rtl/bp_pht_local_if.sv
// Fetch-request, training and prediction signals of the local PHT.
interface bp_pht_local_if;
  import bp_pkg::*;

  logic        req_valid_i;
  logic [63:0] pc_i;
  pht_idx_t    bhr_i;
  logic        update_en_i;
  logic [63:0] pc_u_i;
  pht_idx_t    bhr_u_i;
  logic        taken_u_i;
  logic        ready_o;
  logic        pred_valid_o;
  logic        pred_taken_o;
  ctr2_t       pred_ctr_o;

  modport master (
    output req_valid_i, pc_i, bhr_i, update_en_i, pc_u_i, bhr_u_i, taken_u_i,
    input  ready_o, pred_valid_o, pred_taken_o, pred_ctr_o
  );

  modport slave (
    input  req_valid_i, pc_i, bhr_i, update_en_i, pc_u_i, bhr_u_i, taken_u_i,
    output ready_o, pred_valid_o, pred_taken_o, pred_ctr_o
  );

endinterface

// File: rtl/bp_pht_ram.sv
// 2-bit counter storage: two async read ports (predict, train RMW), one sync write port.
module bp_pht_ram
  import bp_pkg::*;
(
  input  logic     clk_i,
  input  logic     we_i,
  input  pht_idx_t waddr_i,
  input  ctr2_t    wdata_i,
  input  pht_idx_t raddr_a_i,
  output ctr2_t    rdata_a_o,
  input  pht_idx_t raddr_b_i,
  output ctr2_t    rdata_b_o
);

  ctr2_t mem [PHT_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem[raddr_a_i];
  assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/bp_pht_local.sv
// Local-history PHT: init sweep after reset, registered 1-cycle prediction, 2-bit training.
module bp_pht_local
  import bp_pkg::*;
#(
  parameter ctr2_t INIT_CTR = CTR_WNT
) (
  input logic           clk,
  input logic           reset,
  bp_pht_local_if.slave pht
);

  typedef enum logic {StInit, StReady} state_e;

  state_e   state_q;
  pht_idx_t init_idx_q;
  logic     ready_q;
  logic     pred_valid_q;
  logic     pred_taken_q;
  ctr2_t    pred_ctr_q;

  pht_idx_t rd_idx, u_idx, waddr;
  ctr2_t    rd_ctr, u_ctr, upd_ctr, fwd_ctr, wdata;
  logic     do_upd, we;

  always_comb begin
    rd_idx  = pht_hash(pht.bhr_i, pht.pc_i);
    u_idx   = pht_hash(pht.bhr_u_i, pht.pc_u_i);
    upd_ctr = sat_update(u_ctr, pht.taken_u_i);
    do_upd  = (state_q == StReady) && pht.update_en_i;
    // Write port is shared: the sweep owns it in INIT, training owns it in READY.
    we      = reset && ((state_q == StInit) || do_upd);
    waddr   = (state_q == StInit) ? init_idx_q : u_idx;
    wdata   = (state_q == StInit) ? INIT_CTR : upd_ctr;
    fwd_ctr = (do_upd && (u_idx == rd_idx)) ? upd_ctr : rd_ctr;
  end

  bp_pht_ram u_ram (
    .clk_i     (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (rd_idx),
    .rdata_a_o (rd_ctr),
    .raddr_b_i (u_idx),
    .rdata_b_o (u_ctr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StInit;
      init_idx_q   <= '0;
      ready_q      <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= CTR_SNT;
    end else begin
      unique case (state_q)
        StInit: begin
          pred_valid_q <= 1'b0;
          init_idx_q   <= init_idx_q + pht_idx_t'(1);
          if (init_idx_q == '1) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end
        end
        StReady: begin
          pred_valid_q <= pht.req_valid_i;
          if (pht.req_valid_i) begin
            pred_ctr_q   <= fwd_ctr;
            pred_taken_q <= fwd_ctr[1];
          end
        end
      endcase
    end
  end

  assign pht.ready_o      = ready_q;
  assign pht.pred_valid_o = pred_valid_q;
  assign pht.pred_taken_o = pred_taken_q;
  assign pht.pred_ctr_o   = pred_ctr_q;

endmodule
